// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and data access, and drives the pipeline stall vector.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN; default build waits forever for bus_ack.
module mem_bus_arbiter #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [7:0]      mem_wmask,
    input  logic            id_stallreq,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wmask,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic [31:0]     if_rdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            bus_err,
    output logic [5:0]      stall
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_D_DONE = 3'd3;
    localparam logic [2:0] S_F_DONE = 3'd4;

    logic [2:0] state;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign bus_err = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= 8'h00;
            if_rdata  <= 32'h0;
            mem_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            bus_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    // Data access is the older instruction, so it goes first.
                    if (mem_req) begin
                        state     <= S_DATA;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_wmask <= mem_we ? mem_wmask : 8'h00;
                    end else if (if_req) begin
                        state     <= S_FETCH;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_wmask <= 8'h00;
                    end
                end
                S_DATA: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) mem_rdata <= bus_rdata;
                        state   <= S_D_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_we) mem_rdata <= '0;
                        state   <= S_D_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_FETCH: begin
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        if_rdata <= bus_rdata[31:0];
                        state    <= S_F_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        bus_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        if_rdata <= 32'h0;
                        state    <= S_F_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_D_DONE, S_F_DONE: state <= S_IDLE;
                default:            state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the default assignment first keeps this block from inferring a latch.
    always_comb begin
        stall = 6'b000000;
        if ((state == S_IDLE && mem_req) || state == S_DATA)
            stall = 6'b011111;
        else if (id_stallreq)
            stall = 6'b000111;
        else if ((state == S_IDLE && if_req) || state == S_FETCH || (state == S_D_DONE && if_req))
            stall = 6'b000011;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model of pending requests, served oldest-first.
module tb_mem_bus_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            id_stallreq;
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [7:0]      bus_wmask;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;
    logic [31:0]     if_rdata;
    logic [XLEN-1:0] mem_rdata;
    logic            bus_err;
    logic [5:0]      stall;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_mrd;
    logic [63:0] exp_ird;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .id_stallreq(id_stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .if_rdata(if_rdata), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stall from the pipeline's point of view: an outstanding data access stops everything up to mem,
    // a load-use hazard stops up to id, an outstanding fetch stops pc and if.
    function automatic logic [5:0] model_stall(input bit mem_pend, input bit if_pend, input bit hz);
        if (mem_pend) return 6'h1F;
        if (hz)       return 6'h07;
        if (if_pend)  return 6'h03;
        return 6'h00;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run(input bit want_mem, input bit want_if, input bit we,
                       input logic [63:0] maddr, input logic [63:0] wdata, input logic [7:0] wmask,
                       input logic [63:0] iaddr, input int dm, input int di,
                       input logic [63:0] rdm, input logic [63:0] rdi, input bit hz);
        bit mp;
        bit fp;
        bit serve_m;
        int d;
        logic [63:0] ackd;
        mp = want_mem;
        fp = want_if;
        mem_req = want_mem; mem_we = we; mem_addr = maddr; mem_wdata = wdata; mem_wmask = wmask;
        if_req = want_if; if_addr = iaddr; id_stallreq = hz;
        while (mp || fp) begin
            serve_m = mp;
            d = serve_m ? dm : di;
            ackd = serve_m ? rdm : rdi;
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = {$urandom, $urandom};
            @(negedge clk);
            check("idle_stall", 64'(stall), 64'(model_stall(mp, fp, hz)));
            check("idle_bus_req", 64'(bus_req), 64'd0);
            @(posedge clk); #1;
            for (int k = 0; k <= d; k++) begin
                bus_ack = (k == d);
                bus_rdata = (k == d) ? ackd : {$urandom, $urandom};
                @(negedge clk);
                check("busy_bus_req", 64'(bus_req), 64'd1);
                check("busy_addr", bus_addr, serve_m ? maddr : iaddr);
                check("busy_we", 64'(bus_we), 64'(serve_m && we));
                check("busy_wmask", 64'(bus_wmask), (serve_m && we) ? 64'(wmask) : 64'd0);
                if (serve_m && we) check("busy_wdata", bus_wdata, wdata);
                check("busy_stall", 64'(stall), 64'(model_stall(mp, fp, hz)));
                @(posedge clk); #1;
            end
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = {$urandom, $urandom};
            if (serve_m) begin
                mp = 1'b0;
                mem_req = 1'b0;
                if (!we) exp_mrd = ackd;
            end else begin
                fp = 1'b0;
                if_req = 1'b0;
                exp_ird = {32'h0, ackd[31:0]};
            end
            @(negedge clk);
            check("done_bus_req", 64'(bus_req), 64'd0);
            check("done_mem_rdata", mem_rdata, exp_mrd);
            check("done_if_rdata", 64'(if_rdata), exp_ird);
            check("done_bus_err", 64'(bus_err), 64'd0);
            check("done_stall", 64'(stall), 64'(model_stall(mp, fp, hz)));
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        id_stallreq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
        mem_wdata = '0; mem_wmask = '0; id_stallreq = 0; bus_ack = 0; bus_rdata = '0;
        exp_mrd = '0; exp_ird = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_we", 64'(bus_we), 64'd0);
        check("rst_bus_addr", bus_addr, 64'd0);
        check("rst_bus_wdata", bus_wdata, 64'd0);
        check("rst_bus_wmask", 64'(bus_wmask), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_mem_rdata", mem_rdata, 64'd0);
        check("rst_bus_err", 64'(bus_err), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1 load, ack on the second bus cycle
        run(1, 0, 0, 64'h80, 64'h0, 8'h00, 64'h0, 1, 0, 64'h1122334455667788, 64'h0, 0);
        // T2 contention: data first, then fetch
        run(1, 1, 0, 64'h1000, 64'h0, 8'h00, 64'h2000, 0, 2,
            64'hA5A5A5A5_5A5A5A5A, 64'hCAFEF00D_13579BDF, 0);
        // T3 store leaves mem_rdata alone
        run(1, 0, 1, 64'h3008, 64'hDEADBEEF, 8'h0F, 64'h0, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);

        // T4 hazard alone, then hazard under an active data access
        id_stallreq = 1'b1;
        @(negedge clk);
        check("hazard_only_stall", 64'(stall), 64'h07);
        @(posedge clk); #1;
        run(1, 0, 0, 64'h40, 64'h0, 8'h00, 64'h0, 2, 0, 64'h0123456789ABCDEF, 64'h0, 1);

        // Ack with nothing outstanding is ignored
        bus_ack = 1'b1;
        bus_rdata = 64'hBAD0BAD0_BAD0BAD0;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", 64'(bus_req), 64'd0);
        check("stray_ack_mem_rdata", mem_rdata, exp_mrd);
        check("stray_ack_if_rdata", 64'(if_rdata), exp_ird);
        @(posedge clk); #1;

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run(kind != 2, kind >= 2, kind == 1,
                {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end

        // T5 reset in the middle of a data access; the late ack must not latch
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h500; id_stallreq = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_in_data", 64'(bus_req), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_req = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 64'h7777_8888_9999_AAAA;
        exp_mrd = '0;
        exp_ird = '0;
        @(negedge clk);
        check("t5_bus_req", 64'(bus_req), 64'd0);
        check("t5_stall", 64'(stall), 64'd0);
        check("t5_mem_rdata_rst", mem_rdata, 64'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("t5_late_ack_mem_rdata", mem_rdata, 64'd0);
        check("t5_late_ack_bus_req", 64'(bus_req), 64'd0);
        @(posedge clk); #1;
        run(1, 1, 0, 64'h600, 64'h0, 8'h00, 64'h700, 0, 0, 64'h55, 64'h66, 0);

`ifdef BUS_TIMEOUT_EN
        // T6 watchdog: no ack ever arrives
        begin
            int busy;
            busy = 0;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h900;
            @(posedge clk); #1;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (bus_req !== 1'b1) break;
                busy++;
            end
            check("t6_busy_cycles", 64'(busy), 64'd255);
            check("t6_bus_err", 64'(bus_err), 64'd1);
            check("t6_mem_rdata", mem_rdata, 64'd0);
            check("t6_stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            mem_req = 1'b0;
            @(negedge clk);
            check("t6_err_pulse", 64'(bus_err), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
